// File: rtl/decoder_stage_if.sv
// rtl/decoder_stage_if.sv - fetch-side and exec-side signals of the RV32 decode stage
interface decoder_stage_if #(
  parameter int XLEN     = 32,
  parameter int BRMASK_W = 6
);
  logic                I_flush;
  logic                I_valid;
  logic                O_ready;
  logic [XLEN-1:0]     I_instr;
  logic [XLEN-1:0]     I_pc;
  logic                O_valid;
  logic                I_ready;
  logic [XLEN-1:0]     O_pc;
  logic [4:0]          O_rs1;
  logic [4:0]          O_rs2;
  logic [4:0]          O_rd;
  logic [XLEN-1:0]     O_imm;
  logic [BRMASK_W-1:0] O_branchmask;
  logic [4:0]          O_alu_oper;
  logic                O_alu_s1_sel;
  logic [1:0]          O_alu_s2_sel;
  logic [2:0]          O_next_stage;
  logic                O_wb_from_alu;
  logic                O_wb_from_imm;
  logic                O_next_pc_from_alu;
  logic [1:0]          O_reg_input_sel;
  logic                O_illegal;

  modport master (
    output I_flush, I_valid, I_instr, I_pc, I_ready,
    input  O_ready, O_valid, O_pc, O_rs1, O_rs2, O_rd, O_imm, O_branchmask,
           O_alu_oper, O_alu_s1_sel, O_alu_s2_sel, O_next_stage, O_wb_from_alu,
           O_wb_from_imm, O_next_pc_from_alu, O_reg_input_sel, O_illegal
  );

  modport slave (
    input  I_flush, I_valid, I_instr, I_pc, I_ready,
    output O_ready, O_valid, O_pc, O_rs1, O_rs2, O_rd, O_imm, O_branchmask,
           O_alu_oper, O_alu_s1_sel, O_alu_s2_sel, O_next_stage, O_wb_from_alu,
           O_wb_from_imm, O_next_pc_from_alu, O_reg_input_sel, O_illegal
  );
endinterface

// File: rtl/decoder_stage.sv
// rtl/decoder_stage.sv - registered RV32 decode stage with illegal detection and optional skid buffer
module decoder_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter bit SKID     = 1'b1,
  parameter int BRMASK_W = 6
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  decoder_stage_if.slave  bus
);
  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_SUB  = 5'd1;
  localparam logic [4:0] ALUOP_SLL  = 5'd2;
  localparam logic [4:0] ALUOP_SLT  = 5'd3;
  localparam logic [4:0] ALUOP_SLTU = 5'd4;
  localparam logic [4:0] ALUOP_XOR  = 5'd5;
  localparam logic [4:0] ALUOP_SRL  = 5'd6;
  localparam logic [4:0] ALUOP_SRA  = 5'd7;
  localparam logic [4:0] ALUOP_OR   = 5'd8;
  localparam logic [4:0] ALUOP_AND  = 5'd9;
  localparam logic [4:0] ALUOP_MUL  = 5'd10;

  localparam logic       MUX_ALUDAT1_REGVAL1 = 1'b0;
  localparam logic       MUX_ALUDAT1_PC      = 1'b1;
  localparam logic [1:0] MUX_ALUDAT2_REGVAL2 = 2'd0;
  localparam logic [1:0] MUX_ALUDAT2_IMM     = 2'd1;
  localparam logic [1:0] MUX_REGINPUT_ALU    = 2'd0;
  localparam logic [1:0] MUX_REGINPUT_IMM    = 2'd1;

  localparam logic [2:0] EXEC_TO_FETCH  = 3'd0;
  localparam logic [2:0] EXEC_TO_LOAD   = 3'd1;
  localparam logic [2:0] EXEC_TO_STORE  = 3'd2;
  localparam logic [2:0] EXEC_TO_BRANCH = 3'd3;
  localparam logic [2:0] EXEC_TO_SYSTEM = 3'd4;
  localparam logic [2:0] EXEC_TO_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     imm;
    logic [BRMASK_W-1:0] branchmask;
    logic [4:0]          alu_oper;
    logic                alu_s1_sel;
    logic [1:0]          alu_s2_sel;
    logic [2:0]          next_stage;
    logic                wb_from_alu;
    logic                wb_from_imm;
    logic                next_pc_from_alu;
    logic [1:0]          reg_input_sel;
    logic                illegal;
  } bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALUOP_ADD;
      3'b001:  base_op = ALUOP_SLL;
      3'b010:  base_op = ALUOP_SLT;
      3'b011:  base_op = ALUOP_SLTU;
      3'b100:  base_op = ALUOP_XOR;
      3'b101:  base_op = ALUOP_SRL;
      3'b110:  base_op = ALUOP_OR;
      default: base_op = ALUOP_AND;
    endcase
  endfunction

  bundle_t     dec;
  bundle_t     head_q, head_d, tail_q, tail_d;
  state_t      state_q, state_d;
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        ill;
  logic        out_valid, in_ready, accept, pop;

  assign instr = bus.I_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  always_comb begin
    dec               = '0;
    dec.pc            = bus.I_pc;
    dec.rs1           = instr[19:15];
    dec.rs2           = instr[24:20];
    dec.rd            = instr[11:7];
    dec.imm           = {{20{instr[31]}}, instr[31:20]};
    dec.alu_oper      = ALUOP_ADD;
    dec.alu_s1_sel    = MUX_ALUDAT1_REGVAL1;
    dec.alu_s2_sel    = MUX_ALUDAT2_REGVAL2;
    dec.next_stage    = EXEC_TO_FETCH;
    dec.reg_input_sel = MUX_REGINPUT_ALU;
    ill               = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.wb_from_alu = 1'b1;
        case (f7)
          7'b0000000: dec.alu_oper = base_op(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu_oper = ALUOP_SUB;
            else if (f3 == 3'b101) dec.alu_oper = ALUOP_SRA;
            else                   ill = 1'b1;
          end
          7'b0000001: begin
            // MUL..REMU are contiguous codes ordered by funct3
            if (ENABLE_M) dec.alu_oper = ALUOP_MUL + {2'b00, f3};
            else          ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.wb_from_alu = 1'b1;
        dec.alu_s2_sel  = MUX_ALUDAT2_IMM;
        dec.alu_oper    = base_op(f3);
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec.alu_oper = ALUOP_SRA;
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.alu_s2_sel = MUX_ALUDAT2_IMM;
        dec.next_stage = EXEC_TO_LOAD;
      end
      OPC_STORE: begin
        dec.imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.alu_s2_sel = MUX_ALUDAT2_IMM;
        dec.next_stage = EXEC_TO_STORE;
      end
      OPC_JAL, OPC_JALR: begin
        if (opc == OPC_JAL) begin
          dec.imm        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          dec.alu_s1_sel = MUX_ALUDAT1_PC;
        end
        dec.alu_s2_sel       = MUX_ALUDAT2_IMM;
        dec.wb_from_alu      = 1'b1;
        dec.next_pc_from_alu = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.next_stage = EXEC_TO_BRANCH;
        case (f3)
          3'b000:  dec.branchmask = BRMASK_W'(1) << 0;
          3'b001:  dec.branchmask = BRMASK_W'(1) << 1;
          3'b100:  dec.branchmask = BRMASK_W'(1) << 2;
          3'b101:  dec.branchmask = BRMASK_W'(1) << 3;
          3'b110:  dec.branchmask = BRMASK_W'(1) << 4;
          3'b111:  dec.branchmask = BRMASK_W'(1) << 5;
          default: ill = 1'b1;
        endcase
      end
      OPC_AUIPC: begin
        dec.imm         = {instr[31:12], 12'b0};
        dec.alu_s1_sel  = MUX_ALUDAT1_PC;
        dec.alu_s2_sel  = MUX_ALUDAT2_IMM;
        dec.wb_from_alu = 1'b1;
      end
      OPC_LUI: begin
        dec.imm           = {instr[31:12], 12'b0};
        dec.wb_from_imm   = 1'b1;
        dec.reg_input_sel = MUX_REGINPUT_IMM;
      end
      OPC_MISCMEM: dec.next_stage = EXEC_TO_FETCH;
      OPC_SYSTEM:  dec.next_stage = EXEC_TO_SYSTEM;
      default:     ill = 1'b1;
    endcase
    if (ill || instr[1:0] != 2'b11 || instr == 32'h0 || instr == 32'hFFFF_FFFF) begin
      dec.illegal          = 1'b1;
      dec.next_stage       = EXEC_TO_TRAP;
      dec.alu_oper         = ALUOP_ADD;
      dec.alu_s1_sel       = MUX_ALUDAT1_REGVAL1;
      dec.alu_s2_sel       = MUX_ALUDAT2_REGVAL2;
      dec.wb_from_alu      = 1'b0;
      dec.wb_from_imm      = 1'b0;
      dec.next_pc_from_alu = 1'b0;
      dec.reg_input_sel    = MUX_REGINPUT_ALU;
      dec.branchmask       = '0;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = SKID ? (state_q != ST_TWO) : (!out_valid || bus.I_ready);
  assign accept    = bus.I_valid && in_ready;
  assign pop       = out_valid && bus.I_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.I_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          head_d  = dec;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          // without SKID accept implies pop here, so TWO is unreachable
          if (accept && pop) begin
            head_d = dec;
          end else if (accept) begin
            tail_d  = dec;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.O_valid            = out_valid;
  assign bus.O_ready            = in_ready;
  assign bus.O_pc               = head_q.pc;
  assign bus.O_rs1              = head_q.rs1;
  assign bus.O_rs2              = head_q.rs2;
  assign bus.O_rd               = head_q.rd;
  assign bus.O_imm              = head_q.imm;
  assign bus.O_branchmask       = head_q.branchmask;
  assign bus.O_alu_oper         = head_q.alu_oper;
  assign bus.O_alu_s1_sel       = head_q.alu_s1_sel;
  assign bus.O_alu_s2_sel       = head_q.alu_s2_sel;
  assign bus.O_next_stage       = head_q.next_stage;
  assign bus.O_wb_from_alu      = head_q.wb_from_alu;
  assign bus.O_wb_from_imm      = head_q.wb_from_imm;
  assign bus.O_next_pc_from_alu = head_q.next_pc_from_alu;
  assign bus.O_reg_input_sel    = head_q.reg_input_sel;
  assign bus.O_illegal          = head_q.illegal;
endmodule

// File: tb/tb_decoder_stage.sv
// tb/tb_decoder_stage.sv - directed bench: SKID=1/M=1 and SKID=0/M=0 stages fed the same stream
module tb_decoder_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  decoder_stage_if #(.XLEN(32), .BRMASK_W(6)) ifa ();
  decoder_stage_if #(.XLEN(32), .BRMASK_W(6)) ifb ();

  assign ifb.I_flush = ifa.I_flush;
  assign ifb.I_valid = ifa.I_valid;
  assign ifb.I_instr = ifa.I_instr;
  assign ifb.I_pc    = ifa.I_pc;
  assign ifb.I_ready = ifa.I_ready;

  decoder_stage #(.XLEN(32), .ENABLE_M(1'b1), .SKID(1'b1), .BRMASK_W(6)) dut_a (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (ifa.slave)
  );

  decoder_stage #(.XLEN(32), .ENABLE_M(1'b0), .SKID(1'b0), .BRMASK_W(6)) dut_b (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    ifa.I_valid = v;
    ifa.I_instr = ins;
    ifa.I_pc    = pc;
    ifa.I_ready = rdy;
    ifa.I_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_x1(input int k);
    addi_x1 = (32'(k) << 20) | 32'h0000_0093;
  endfunction

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_valid", 32'(ifa.O_valid), 32'd0);
    chk("rst_next_stage", 32'(ifa.O_next_stage), 32'd0);
    chk("rst_illegal", 32'(ifa.O_illegal), 32'd0);
    chk("rst_imm", ifa.O_imm, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready_a", 32'(ifa.O_ready), 32'd1);
    chk("rst_ready_b", 32'(ifb.O_ready), 32'd1);

    // addi x1,x2,5
    drive(1'b1, 32'h0051_0093, 32'h100, 1'b1, 1'b0);
    tick();
    chk("addi_valid", 32'(ifa.O_valid), 32'd1);
    chk("addi_rs1", 32'(ifa.O_rs1), 32'd2);
    chk("addi_rd", 32'(ifa.O_rd), 32'd1);
    chk("addi_imm", ifa.O_imm, 32'd5);
    chk("addi_alu", 32'(ifa.O_alu_oper), 32'd0);
    chk("addi_s2", 32'(ifa.O_alu_s2_sel), 32'd1);
    chk("addi_wb_alu", 32'(ifa.O_wb_from_alu), 32'd1);
    chk("addi_next", 32'(ifa.O_next_stage), 32'd0);
    chk("addi_pc", ifa.O_pc, 32'h100);

    // mul x3,x1,x2
    drive(1'b1, 32'h0220_81B3, 32'h104, 1'b1, 1'b0);
    tick();
    chk("mul_alu_m1", 32'(ifa.O_alu_oper), 32'd10);
    chk("mul_illegal_m1", 32'(ifa.O_illegal), 32'd0);
    chk("mul_rd", 32'(ifa.O_rd), 32'd3);
    chk("mul_illegal_m0", 32'(ifb.O_illegal), 32'd1);
    chk("mul_next_m0", 32'(ifb.O_next_stage), 32'd5);
    chk("mul_wb_m0", 32'(ifb.O_wb_from_alu), 32'd0);

    // beq x1,x2,+8
    drive(1'b1, 32'h0020_8463, 32'h108, 1'b1, 1'b0);
    tick();
    chk("beq_imm", ifa.O_imm, 32'd8);
    chk("beq_mask", 32'(ifa.O_branchmask), 32'b000001);
    chk("beq_next", 32'(ifa.O_next_stage), 32'd3);

    // branch funct3=010
    drive(1'b1, 32'h0020_A463, 32'h10C, 1'b1, 1'b0);
    tick();
    chk("br010_illegal", 32'(ifa.O_illegal), 32'd1);
    chk("br010_mask", 32'(ifa.O_branchmask), 32'd0);
    chk("br010_next", 32'(ifa.O_next_stage), 32'd5);

    // lui x5,0x12345
    drive(1'b1, 32'h1234_52B7, 32'h110, 1'b1, 1'b0);
    tick();
    chk("lui_imm", ifa.O_imm, 32'h1234_5000);
    chk("lui_wb_imm", 32'(ifa.O_wb_from_imm), 32'd1);
    chk("lui_regsel", 32'(ifa.O_reg_input_sel), 32'd1);
    chk("lui_wb_alu", 32'(ifa.O_wb_from_alu), 32'd0);

    drive(1'b1, 32'h0000_0000, 32'h114, 1'b1, 1'b0);
    tick();
    chk("zero_illegal", 32'(ifa.O_illegal), 32'd1);
    chk("zero_next", 32'(ifa.O_next_stage), 32'd5);

    drive(1'b1, 32'hFFFF_FFFF, 32'h118, 1'b1, 1'b0);
    tick();
    chk("ones_illegal", 32'(ifa.O_illegal), 32'd1);

    // srai x1,x2,3 legal; slli with funct7=0100000 illegal
    drive(1'b1, 32'h4031_5093, 32'h11C, 1'b1, 1'b0);
    tick();
    chk("srai_alu", 32'(ifa.O_alu_oper), 32'd7);
    chk("srai_illegal", 32'(ifa.O_illegal), 32'd0);
    drive(1'b1, 32'h4031_1093, 32'h120, 1'b1, 1'b0);
    tick();
    chk("slli_bad_illegal", 32'(ifa.O_illegal), 32'd1);

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain_valid", 32'(ifa.O_valid), 32'd0);

    // backpressure: A accepted, B accepted, C refused on stage a
    drive(1'b1, addi_x1(1), 32'h204, 1'b0, 1'b0);
    tick();
    chk("bp1_ready_a", 32'(ifa.O_ready), 32'd1);
    chk("bp1_ready_b", 32'(ifb.O_ready), 32'd0);
    chk("bp1_imm", ifa.O_imm, 32'd1);
    drive(1'b1, addi_x1(2), 32'h208, 1'b0, 1'b0);
    tick();
    chk("bp2_ready_a", 32'(ifa.O_ready), 32'd0);
    chk("bp2_valid", 32'(ifa.O_valid), 32'd1);
    chk("bp2_imm", ifa.O_imm, 32'd1);
    drive(1'b1, addi_x1(3), 32'h20C, 1'b0, 1'b0);
    tick();
    chk("bp3_ready_a", 32'(ifa.O_ready), 32'd0);
    chk("bp3_imm", ifa.O_imm, 32'd1);
    chk("bp3_pc", ifa.O_pc, 32'h204);
    chk("bp3_ready_b", 32'(ifb.O_ready), 32'd0);
    drive(1'b1, addi_x1(3), 32'h20C, 1'b1, 1'b0);
    tick();
    chk("rel1_imm", ifa.O_imm, 32'd2);
    chk("rel1_ready_a", 32'(ifa.O_ready), 32'd1);
    chk("rel1_ready_b", 32'(ifb.O_ready), 32'd1);
    tick();
    chk("rel2_imm", ifa.O_imm, 32'd3);
    chk("rel2_pc", ifa.O_pc, 32'h20C);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("rel3_valid", 32'(ifa.O_valid), 32'd0);

    // flush with two held entries and a valid input
    drive(1'b1, addi_x1(4), 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, addi_x1(5), 32'h304, 1'b0, 1'b0);
    tick();
    chk("fl_full_ready", 32'(ifa.O_ready), 32'd0);
    drive(1'b1, addi_x1(6), 32'h308, 1'b0, 1'b1);
    tick();
    chk("fl_valid_a", 32'(ifa.O_valid), 32'd0);
    chk("fl_ready_a", 32'(ifa.O_ready), 32'd1);
    chk("fl_valid_b", 32'(ifb.O_valid), 32'd0);
    // flush from one entry while the stage could accept
    drive(1'b1, addi_x1(7), 32'h30C, 1'b1, 1'b0);
    tick();
    drive(1'b1, addi_x1(8), 32'h310, 1'b1, 1'b1);
    tick();
    chk("fl1_valid_a", 32'(ifa.O_valid), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("fl1_after_valid", 32'(ifa.O_valid), 32'd0);

    // async reset mid-stream
    drive(1'b1, addi_x1(9), 32'h400, 1'b0, 1'b0);
    tick();
    chk("ar_pre_valid", 32'(ifa.O_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_a", 32'(ifa.O_valid), 32'd0);
    chk("ar_valid_b", 32'(ifb.O_valid), 32'd0);
    chk("ar_imm", ifa.O_imm, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decoder_stage.md
Name: decoder_stage

Overview:
Registered, parametrised RV32 decode stage. It sits between the fetch and exec stages and adds a valid/ready handshake, a flush input and an optional skid buffer. It decodes the full instruction word into an exec control bundle. Unlike the combinational decoder it detects illegal instructions, makes M-extension support configurable, and drives every control field explicitly each cycle, so no field holds a stale value.

Parameters:
XLEN, 32, instruction/PC/immediate width; only 32 is legal.
ENABLE_M, 1, 1 = decode MUL/DIV/REM; 0 = OP with funct7=0000001 is illegal.
SKID, 1, 1 = two-entry output buffer (in_ready independent of out_ready); 0 = single register (in_ready = !out_valid_q | out_ready).
BRMASK_W, 6, width of the one-hot branch mask (6 = BEQ,BNE,BLT,BGE,BLTU,BGEU).

Ports:
I_clk  in  1  clock
I_rst_n  in  1  asynchronous active-low reset
I_flush  in  1  drop all held entries this cycle
I_valid  in  1  I_instr/I_pc valid
O_ready  out  1  stage accepts input
I_instr  in  XLEN  instruction word
I_pc  in  XLEN  PC of instruction
O_valid  out  1  decoded bundle valid
I_ready  in  1  exec accepts bundle
O_pc  out  XLEN  PC passthrough
O_rs1/O_rs2/O_rd  out  5 each  register fields
O_imm  out  XLEN  sign-extended immediate (S/SB/U/UJ/I by opcode)
O_branchmask  out  BRMASK_W  one-hot branch condition, 0 for non-branch
O_alu_oper  out  5  ALUOP_* code
O_alu_s1_sel  out  1  MUX_ALUDAT1_*
O_alu_s2_sel  out  2  MUX_ALUDAT2_*
O_next_stage  out  3  EXEC_TO_*
O_wb_from_alu, O_wb_from_imm, O_next_pc_from_alu  out  1 each
O_reg_input_sel  out  2  MUX_REGINPUT_*
O_illegal  out  1  instruction is illegal; O_next_stage = EXEC_TO_TRAP

Behaviour:
- Reset (async assert, sync release): O_valid=0, all bundle fields 0, O_next_stage=EXEC_TO_FETCH, O_illegal=0, O_ready=1 after release.
- Decode is combinational on I_instr. Result and I_pc are captured on the accepting edge (I_valid & O_ready). Latency is 1 cycle; throughput is 1/cycle while I_ready=1.
- Default per instruction: alu_oper=ALUOP_ADD, s1=REGVAL1, s2=REGVAL2, all flags 0, reg_input_sel=MUX_REGINPUT_ALU, branchmask=0, illegal=0.
- Opcode map matches the existing exec contract:
  - OP / OPIMM: ALU op from funct3/funct7, wb_from_alu=1, ->FETCH.
  - LOAD / STORE: ADD with IMM, ->LOAD / ->STORE.
  - JAL / JALR: ADD, s1=PC for JAL and REGVAL1 for JALR, s2=IMM, wb_from_alu=1, next_pc_from_alu=1, ->FETCH.
  - BRANCH: ->BRANCH, one-hot mask from funct3.
  - AUIPC: PC+IMM, wb_from_alu=1.
  - LUI: wb_from_imm=1, reg_input_sel=IMM.
  - MISCMEM: ->FETCH. SYSTEM: ->SYSTEM.
- Illegal (O_illegal=1, ->TRAP, all write flags 0) when any of these holds:
  - I_instr[1:0]!=2'b11, or opcode is unlisted;
  - BRANCH with funct3 010 or 011;
  - OP with funct7 not in {0000000, 0100000 for ADD/SRL funct3, 0000001 when ENABLE_M};
  - OPIMM shift with funct7 not 0000000 (or 0100000 for SRAI);
  - instruction word all-zero or all-one.
- Handshake: O_valid stays high and the bundle stays stable until I_ready. With O_valid=0 the bundle is don't-care.
- SKID=1: states EMPTY, ONE, TWO.
  - EMPTY -accept-> ONE.
  - ONE: accept & !pop stays in ... -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE (new entry).
  - TWO: pop -> ONE (second entry promoted). O_ready=0 only in TWO.
- SKID=0: single register. Simultaneous pop and accept replaces the entry with no bubble.
- I_flush: all entries invalidated at the next edge and the input that cycle is not captured. Flush has priority over accept and pop. O_ready=1 on the following cycle.
- Reset mid-transfer: held entries are lost and O_valid drops immediately (async).

Test Plan:
- addi x1,x2,5 (0x00510093), I_ready=1 -> next cycle O_valid=1, rs1=2, rd=1, imm=5, ALUOP_ADD, s2=IMM, wb_from_alu=1, ->FETCH.
- mul x3,x1,x2 (0x022081B3): ENABLE_M=1 -> ALUOP_MUL, illegal=0; ENABLE_M=0 -> illegal=1, ->TRAP, wb_from_alu=0.
- beq x1,x2,+8 (0x00208463) -> imm=8, branchmask=6'b000001, ->BRANCH; funct3=010 variant -> illegal=1, mask=0.
- lui x5,0x12345 (0x123452B7) -> imm=0x12345000, wb_from_imm=1, reg_input_sel=IMM; 0x00000000 -> illegal.
- SKID=1, I_valid=1 every cycle, I_ready held 0 for 3 cycles -> O_ready falls after 2 accepts, first bundle held stable, no loss or duplication after release; SKID=0 -> O_ready = I_ready while full.
- Two entries held, I_flush=1 together with I_valid=1 -> next cycle O_valid=0, O_ready=1, flushed instruction never appears; assert I_rst_n=0 mid-stream -> O_valid=0 without a clock edge.
